// File: rtl/lc3_control_unit.sv
// LC-3 multicycle control unit: microsequencer FSM, NZP condition codes and BEN.
// Control outputs are Moore-decoded from the state and held low while RESET is high.
module lc3_control_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] BUS,
  input  logic [15:0] IR,
  input  logic        READY,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        GateMARMUX,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GatePC,
  output logic        MARMUXsel,
  output logic        ADDR1MUXsel,
  output logic [1:0]  ADDR2MUXsel,
  output logic [1:0]  PCMUXsel,
  output logic [1:0]  SR1MUXsel,
  output logic [1:0]  DRMUXsel,
  output logic        CS,
  output logic        WE,
  output logic [1:0]  ALUK,
  output logic        N,
  output logic        Z,
  output logic        P,
  output logic        BEN
);

  localparam logic [5:0] S0  = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3;
  localparam logic [5:0] S4  = 6'd4,  S5  = 6'd5,  S6  = 6'd6,  S7  = 6'd7;
  localparam logic [5:0] S9  = 6'd9,  S10 = 6'd10, S11 = 6'd11, S12 = 6'd12;
  localparam logic [5:0] S14 = 6'd14, S15 = 6'd15, S16 = 6'd16, S18 = 6'd18;
  localparam logic [5:0] S20 = 6'd20, S21 = 6'd21, S22 = 6'd22, S23 = 6'd23;
  localparam logic [5:0] S24 = 6'd24, S25 = 6'd25, S26 = 6'd26, S27 = 6'd27;
  localparam logic [5:0] S28 = 6'd28, S29 = 6'd29, S30 = 6'd30, S31 = 6'd31;
  localparam logic [5:0] S32 = 6'd32, S33 = 6'd33, S35 = 6'd35;

  logic [5:0] state_q, state_d;
  logic       n_q, n_d, z_q, z_d, p_q, p_d, ben_q, ben_d;

  logic       ld_mar_dec, ld_mdr_dec, ld_ir_dec, ld_pc_dec, ld_reg_dec, ld_ben_dec, ld_cc_dec;
  logic       gate_marmux_dec, gate_mdr_dec, gate_alu_dec, gate_pc_dec;
  logic       marmux_dec, addr1_dec, cs_dec, we_dec;
  logic [1:0] addr2_dec, pcmux_dec, sr1mux_dec, drmux_dec, aluk_dec;

  // Offsets and base-register fields are consumed by the datapath, not here.
  logic       ir_unused;
  assign ir_unused = ^IR[8:0];

  always_comb begin
    ld_mar_dec      = 1'b0;
    ld_mdr_dec      = 1'b0;
    ld_ir_dec       = 1'b0;
    ld_pc_dec       = 1'b0;
    ld_reg_dec      = 1'b0;
    ld_ben_dec      = 1'b0;
    ld_cc_dec       = 1'b0;
    gate_marmux_dec = 1'b0;
    gate_mdr_dec    = 1'b0;
    gate_alu_dec    = 1'b0;
    gate_pc_dec     = 1'b0;
    marmux_dec      = 1'b0;
    addr1_dec       = 1'b0;
    addr2_dec       = 2'd0;
    pcmux_dec       = 2'd0;
    sr1mux_dec      = 2'd0;
    drmux_dec       = 2'd0;
    cs_dec          = 1'b0;
    we_dec          = 1'b0;
    aluk_dec        = 2'd0;
    case (state_q)
      S18: begin gate_pc_dec = 1'b1; ld_mar_dec = 1'b1; ld_pc_dec = 1'b1; end
      S33, S24, S25, S29: begin cs_dec = 1'b1; ld_mdr_dec = 1'b1; end
      S35: begin gate_mdr_dec = 1'b1; ld_ir_dec = 1'b1; end
      S32: ld_ben_dec = 1'b1;
      S22: begin addr2_dec = 2'd2; pcmux_dec = 2'd2; ld_pc_dec = 1'b1; end
      S21: begin addr2_dec = 2'd3; pcmux_dec = 2'd2; ld_pc_dec = 1'b1; end
      S12, S20: begin
        sr1mux_dec = 2'd1; addr1_dec = 1'b1; pcmux_dec = 2'd2; ld_pc_dec = 1'b1;
      end
      S4: begin gate_pc_dec = 1'b1; drmux_dec = 2'd1; ld_reg_dec = 1'b1; end
      S1, S5, S9: begin
        sr1mux_dec   = 2'd1;
        gate_alu_dec = 1'b1;
        ld_reg_dec   = 1'b1;
        ld_cc_dec    = 1'b1;
        aluk_dec     = (state_q == S1) ? 2'd0 : (state_q == S5) ? 2'd1 : 2'd2;
      end
      S14: begin
        marmux_dec = 1'b1; addr2_dec = 2'd2; gate_marmux_dec = 1'b1;
        ld_reg_dec = 1'b1; ld_cc_dec = 1'b1;
      end
      S2, S3, S10, S11: begin
        marmux_dec = 1'b1; addr2_dec = 2'd2; gate_marmux_dec = 1'b1; ld_mar_dec = 1'b1;
      end
      S6, S7: begin
        marmux_dec = 1'b1; sr1mux_dec = 2'd1; addr1_dec = 1'b1; addr2_dec = 2'd1;
        gate_marmux_dec = 1'b1; ld_mar_dec = 1'b1;
      end
      S26, S31: begin gate_mdr_dec = 1'b1; ld_mar_dec = 1'b1; end
      S27: begin gate_mdr_dec = 1'b1; ld_reg_dec = 1'b1; ld_cc_dec = 1'b1; end
      S23: begin aluk_dec = 2'd3; gate_alu_dec = 1'b1; ld_mdr_dec = 1'b1; end
      S16: begin cs_dec = 1'b1; we_dec = 1'b1; end
      S15: begin gate_marmux_dec = 1'b1; ld_mar_dec = 1'b1; end
      // TRAP reads the vector table and saves the return address in one cycle.
      S28: begin
        cs_dec = 1'b1; ld_mdr_dec = 1'b1;
        gate_pc_dec = 1'b1; drmux_dec = 2'd1; ld_reg_dec = 1'b1;
      end
      S30: begin gate_mdr_dec = 1'b1; pcmux_dec = 2'd1; ld_pc_dec = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = S18;
    case (state_q)
      S18: state_d = S33;
      S33: state_d = READY ? S35 : S33;
      S35: state_d = S32;
      S32: state_d = (IR[15:12] == 4'd8 || IR[15:12] == 4'd13) ? S18 : {2'b00, IR[15:12]};
      S0:  state_d = ben_q ? S22 : S18;
      S4:  state_d = IR[11] ? S21 : S20;
      S2, S6:  state_d = S25;
      S3, S7:  state_d = S23;
      S10: state_d = S24;
      S11: state_d = S29;
      S24: state_d = READY ? S26 : S24;
      S25: state_d = READY ? S27 : S25;
      S29: state_d = READY ? S31 : S29;
      S26: state_d = S25;
      S31: state_d = S23;
      S23: state_d = S16;
      S16: state_d = READY ? S18 : S16;
      S15: state_d = S28;
      S28: state_d = READY ? S30 : S28;
      default: state_d = S18;
    endcase
  end

  always_comb begin
    n_d   = n_q;
    z_d   = z_q;
    p_d   = p_q;
    ben_d = ben_q;
    if (ld_cc_dec) begin
      n_d = BUS[15];
      z_d = (BUS == 16'h0000);
      p_d = ~BUS[15] & (BUS != 16'h0000);
    end
    if (ld_ben_dec)
      ben_d = (IR[11] & n_q) | (IR[10] & z_q) | (IR[9] & p_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S18;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      p_q     <= 1'b0;
      ben_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      z_q     <= z_d;
      p_q     <= p_d;
      ben_q   <= ben_d;
    end
  end

  assign LD_MAR      = ld_mar_dec & ~RESET;
  assign LD_MDR      = ld_mdr_dec & ~RESET;
  assign LD_IR       = ld_ir_dec & ~RESET;
  assign LD_PC       = ld_pc_dec & ~RESET;
  assign LD_REG      = ld_reg_dec & ~RESET;
  assign LD_BEN      = ld_ben_dec & ~RESET;
  assign LD_CC       = ld_cc_dec & ~RESET;
  assign GateMARMUX  = gate_marmux_dec & ~RESET;
  assign GateMDR     = gate_mdr_dec & ~RESET;
  assign GateALU     = gate_alu_dec & ~RESET;
  assign GatePC      = gate_pc_dec & ~RESET;
  assign MARMUXsel   = marmux_dec & ~RESET;
  assign ADDR1MUXsel = addr1_dec & ~RESET;
  assign ADDR2MUXsel = RESET ? 2'd0 : addr2_dec;
  assign PCMUXsel    = RESET ? 2'd0 : pcmux_dec;
  assign SR1MUXsel   = RESET ? 2'd0 : sr1mux_dec;
  assign DRMUXsel    = RESET ? 2'd0 : drmux_dec;
  assign CS          = cs_dec & ~RESET;
  assign WE          = we_dec & ~RESET;
  assign ALUK        = RESET ? 2'd0 : aluk_dec;

  assign N   = n_q;
  assign Z   = z_q;
  assign P   = p_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: an instruction-level model predicts every control
// word and the NZP/BEN registers each cycle, plus directed literal checks.
module tb_lc3_control_unit;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_ben, ld_cc;
    logic       gate_marmux, gate_mdr, gate_alu, gate_pc;
    logic       marmux, addr1;
    logic [1:0] addr2, pcmux, sr1mux, drmux;
    logic       cs, we;
    logic [1:0] aluk;
  } ctrl_t;

  logic        CLK, RESET, READY;
  logic [15:0] BUS, IR;
  logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_BEN, LD_CC;
  logic        GateMARMUX, GateMDR, GateALU, GatePC, MARMUXsel, ADDR1MUXsel;
  logic [1:0]  ADDR2MUXsel, PCMUXsel, SR1MUXsel, DRMUXsel, ALUK;
  logic        CS, WE, N, Z, P, BEN;

  lc3_control_unit dut (
    .CLK(CLK), .RESET(RESET), .BUS(BUS), .IR(IR), .READY(READY),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .GateMARMUX(GateMARMUX), .GateMDR(GateMDR), .GateALU(GateALU), .GatePC(GatePC),
    .MARMUXsel(MARMUXsel), .ADDR1MUXsel(ADDR1MUXsel), .ADDR2MUXsel(ADDR2MUXsel),
    .PCMUXsel(PCMUXsel), .SR1MUXsel(SR1MUXsel), .DRMUXsel(DRMUXsel),
    .CS(CS), .WE(WE), .ALUK(ALUK), .N(N), .Z(Z), .P(P), .BEN(BEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_vec = 0;
  int    n_bad = 0;
  bit    chk_en = 0;
  bit    rec_en = 0;
  ctrl_t rec_q[$];
  int    st_q[$];
  int    sti_seq[9] = '{18, 33, 35, 32, 11, 29, 31, 23, 16};

  // Model state: current microstate number and architectural flags.
  int   m_state;
  logic m_n, m_z, m_p, m_ben;

  ctrl_t got_c;
  always_comb begin
    got_c = '0;
    got_c.ld_mar = LD_MAR;  got_c.ld_mdr = LD_MDR;  got_c.ld_ir = LD_IR;
    got_c.ld_pc = LD_PC;    got_c.ld_reg = LD_REG;  got_c.ld_ben = LD_BEN;
    got_c.ld_cc = LD_CC;    got_c.gate_marmux = GateMARMUX;
    got_c.gate_mdr = GateMDR; got_c.gate_alu = GateALU; got_c.gate_pc = GatePC;
    got_c.marmux = MARMUXsel; got_c.addr1 = ADDR1MUXsel; got_c.addr2 = ADDR2MUXsel;
    got_c.pcmux = PCMUXsel; got_c.sr1mux = SR1MUXsel; got_c.drmux = DRMUXsel;
    got_c.cs = CS; got_c.we = WE; got_c.aluk = ALUK;
  end

  // Register transfers each microstate performs, expressed as datapath controls.
  function automatic ctrl_t expect_ctrl(input int st);
    ctrl_t c;
    c = '0;
    case (st)
      18: begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      33, 24, 25, 29: begin c.cs = 1; c.ld_mdr = 1; end
      28: begin c.cs = 1; c.ld_mdr = 1; c.gate_pc = 1; c.drmux = 2'd1; c.ld_reg = 1; end
      16: begin c.cs = 1; c.we = 1; end
      35: begin c.gate_mdr = 1; c.ld_ir = 1; end
      26, 31: begin c.gate_mdr = 1; c.ld_mar = 1; end
      27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      30: begin c.gate_mdr = 1; c.pcmux = 2'd1; c.ld_pc = 1; end
      32: c.ld_ben = 1;
      22: begin c.addr2 = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1; end
      21: begin c.addr2 = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1; end
      12, 20: begin c.sr1mux = 2'd1; c.addr1 = 1; c.pcmux = 2'd2; c.ld_pc = 1; end
      4: begin c.gate_pc = 1; c.drmux = 2'd1; c.ld_reg = 1; end
      1, 5, 9: begin
        c.sr1mux = 2'd1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk = (st == 5) ? 2'd1 : (st == 9) ? 2'd2 : 2'd0;
      end
      14: begin c.marmux = 1; c.addr2 = 2'd2; c.gate_marmux = 1; c.ld_reg = 1; c.ld_cc = 1; end
      2, 3, 10, 11: begin c.marmux = 1; c.addr2 = 2'd2; c.gate_marmux = 1; c.ld_mar = 1; end
      6, 7: begin
        c.marmux = 1; c.sr1mux = 2'd1; c.addr1 = 1; c.addr2 = 2'd1;
        c.gate_marmux = 1; c.ld_mar = 1;
      end
      23: begin c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1; end
      15: begin c.gate_marmux = 1; c.ld_mar = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit is_wait(input int st);
    return (st == 33 || st == 24 || st == 25 || st == 29 || st == 28 || st == 16);
  endfunction

  function automatic int next_of(input int st, input logic rdy, input logic [15:0] ir,
                                 input logic ben);
    int op;
    op = int'(ir[15:12]);
    case (st)
      18: return 33;
      33: return rdy ? 35 : 33;
      35: return 32;
      32: return (op == 8 || op == 13) ? 18 : op;
      0:  return ben ? 22 : 18;
      4:  return ir[11] ? 21 : 20;
      2, 6:  return 25;
      3, 7:  return 23;
      10: return 24;
      11: return 29;
      24: return rdy ? 26 : 24;
      25: return rdy ? 27 : 25;
      29: return rdy ? 31 : 29;
      28: return rdy ? 30 : 28;
      16: return rdy ? 18 : 16;
      26: return 25;
      31: return 23;
      23: return 16;
      15: return 28;
      default: return 18;
    endcase
  endfunction

  always @(posedge CLK) begin
    ctrl_t c;
    logic  old_ben;
    if (RESET) begin
      m_state = 18; m_n = 0; m_z = 1; m_p = 0; m_ben = 0;
    end else begin
      c = expect_ctrl(m_state);
      old_ben = m_ben;
      if (c.ld_ben) m_ben = (IR[11] & m_n) | (IR[10] & m_z) | (IR[9] & m_p);
      if (c.ld_cc) begin
        m_n = BUS[15];
        m_z = (BUS == 16'h0000);
        m_p = !BUS[15] && (BUS != 16'h0000);
      end
      m_state = next_of(m_state, READY, IR, old_ben);
    end
  end

  always @(negedge CLK) begin
    ctrl_t exp_c;
    if (chk_en) begin
      exp_c = RESET ? ctrl_t'('0) : expect_ctrl(m_state);
      n_vec++;
      if (got_c !== exp_c || {N, Z, P, BEN} !== {m_n, m_z, m_p, m_ben}) begin
        n_bad++;
        $display("FAIL cycle state=%0d: ctrl got %h expected %h, NZPB got %b expected %b",
                 m_state, got_c, exp_c, {N, Z, P, BEN}, {m_n, m_z, m_p, m_ben});
      end
      if (rec_en) begin
        rec_q.push_back(got_c);
        st_q.push_back(m_state);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int count_sig(input int sel);
    int c;
    ctrl_t r;
    c = 0;
    foreach (rec_q[i]) begin
      r = rec_q[i];
      case (sel)
        0: if (r.ld_mdr && r.cs) c++;
        1: if (r.ld_ir) c++;
        2: if (r.ld_pc) c++;
        3: if (r.ld_pc && r.pcmux == 2'd2 && r.addr2 == 2'd2 && !r.addr1) c++;
        4: if (r.cs && r.we) c++;
        5: if (r.gate_marmux && !r.marmux && r.ld_mar) c++;
        6: if (r.gate_pc && r.drmux == 2'd1 && r.ld_reg && r.cs && r.ld_mdr) c++;
        7: if (r.gate_mdr && r.pcmux == 2'd1 && r.ld_pc) c++;
        default: ;
      endcase
    end
    return c;
  endfunction

  // Runs one instruction from S18 back to S18; each wait state sees READY low
  // for 'stall' cycles before it goes high.
  task automatic run_instr(input logic [15:0] ir, input logic [15:0] bus, input int stall);
    int waited;
    int guard;
    waited = 0;
    guard  = 0;
    rec_q.delete();
    st_q.delete();
    rec_en = 1;
    IR  = ir;
    BUS = bus;
    do begin
      if (is_wait(m_state)) begin
        READY  = (waited >= stall);
        waited = READY ? 0 : waited + 1;
      end else begin
        READY = 1'b1;
      end
      @(posedge CLK);
      #1;
      guard++;
      if (guard > 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL timeout ir=%h: no return to fetch within 200 cycles", ir);
        break;
      end
    end while (m_state != 18);
    rec_en = 0;
    $display("instr %h bus %h stall %0d: %0d cycles, NZP=%b BEN=%b",
             ir, bus, stall, rec_q.size(), {N, Z, P}, BEN);
  endtask

  initial begin
    int dq[$];
    RESET = 1; READY = 1; IR = 16'h0000; BUS = 16'h0000;
    @(posedge CLK);
    chk_en = 1;
    @(negedge CLK);
    chk("reset_ctrl", 32'(got_c), 32'h0);
    chk("reset_nzpb", {28'h0, N, Z, P, BEN}, 32'h4);
    @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    chk("s18_fetch", {28'h0, GatePC, LD_MAR, LD_PC, |PCMUXsel}, 32'he);
    #1;

    run_instr(16'h1000, 16'h8000, 3);
    chk("fetch_wait_ld_mdr", count_sig(0), 4);
    chk("fetch_ld_ir", count_sig(1), 1);
    chk("cc_neg", {29'h0, N, Z, P}, 3'b100);

    run_instr(16'h1000, 16'h0000, 0);
    chk("add_latency", rec_q.size(), 5);
    chk("cc_zero", {29'h0, N, Z, P}, 3'b010);

    run_instr(16'h1000, 16'h0001, 0);
    chk("cc_pos", {29'h0, N, Z, P}, 3'b001);

    run_instr(16'hC000, 16'h8000, 0);
    chk("cc_hold_jmp", {29'h0, N, Z, P}, 3'b001);

    run_instr(16'h5000, 16'h0000, 0);
    run_instr(16'h0A05, 16'h0000, 0);
    chk("br_not_taken_ben", {31'h0, BEN}, 0);
    chk("br_not_taken_ld_pc", count_sig(2), 1);

    run_instr(16'h1000, 16'h0005, 0);
    run_instr(16'h0A05, 16'h0000, 0);
    chk("br_taken_ben", {31'h0, BEN}, 1);
    chk("br_taken_target", count_sig(3), 1);
    chk("br_taken_latency", rec_q.size(), 6);

    run_instr(16'hB002, 16'h0000, 2);
    foreach (st_q[i])
      if (dq.size() == 0 || dq[dq.size() - 1] != st_q[i]) dq.push_back(st_q[i]);
    chk("sti_seq_len", dq.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("sti_seq_%0d", i), (i < dq.size()) ? dq[i] : -1, sti_seq[i]);
    chk("sti_write_cycles", count_sig(4), 3);

    run_instr(16'hF025, 16'h0000, 1);
    chk("trap_vector", count_sig(5), 1);
    chk("trap_s28", count_sig(6), 2);
    chk("trap_s30", count_sig(7), 1);

    run_instr(16'hE005, 16'h0000, 0);
    run_instr(16'h9000, 16'hFFFF, 0);
    chk("cc_not", {29'h0, N, Z, P}, 3'b100);
    run_instr(16'h6000, 16'h0000, 1);
    run_instr(16'h7000, 16'h0000, 1);
    run_instr(16'hA000, 16'h0001, 1);
    run_instr(16'h4800, 16'h0000, 0);
    run_instr(16'h4000, 16'h0000, 0);
    run_instr(16'h8000, 16'h0000, 0);
    chk("rti_nop_latency", rec_q.size(), 4);
    run_instr(16'hD000, 16'h0000, 0);

    // Reset in the middle of an instruction fetch that is stalled on memory.
    IR = 16'h1000; READY = 0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1;
    @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    chk("midreset_s18", {28'h0, GatePC, LD_MAR, LD_PC, CS}, 32'he);
    chk("midreset_nzpb", {28'h0, N, Z, P, BEN}, 32'h4);
    #1;
    run_instr(16'h1000, 16'h0001, 0);
    chk("after_reset_add", {29'h0, N, Z, P}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_control_unit.md
# lc3_control_unit

Control unit of the LC-3 multicycle CPU. It contains three parts: the microsequencer FSM, the N/Z/P condition-code register, and the branch-enable (BEN) register. It watches the shared 16-bit BUS, the instruction register and the memory READY flag. It drives every load, gate, mux-select and memory-control line of the datapath.

## Interface
Parameters: none.
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- BUS  in  16  shared datapath bus (CC source)
- IR  in  16  instruction register contents
- READY  in  1  memory access complete
- LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_BEN, LD_CC  out  1 each  register loads
- GateMARMUX, GateMDR, GateALU, GatePC  out  1 each  bus drivers (at most one high)
- MARMUXsel  out  1  0=ZEXT(IR[7:0]), 1=address adder
- ADDR1MUXsel  out  1  0=PC, 1=SR1out
- ADDR2MUXsel  out  2  0=0, 1=SEXT(IR[5:0]), 2=SEXT(IR[8:0]), 3=SEXT(IR[10:0])
- PCMUXsel  out  2  0=PC+1, 1=BUS, 2=adder
- SR1MUXsel  out  2  0=IR[11:9], 1=IR[8:6], 2=R6
- DRMUXsel  out  2  0=IR[11:9], 1=R7, 2=R6
- CS  out  1  memory select; also steers MDR input to RAM
- WE  out  1  memory write
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS SR1
- N, Z, P  out  1 each  condition codes
- BEN  out  1  branch enable

## Operation
- Condition codes: on an LD_CC cycle, N=BUS[15]; Z=(BUS==0); P=!N&&!Z.
- BEN: on an LD_BEN cycle, BEN=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
- Controls are Moore outputs decoded from the state. Any signal not listed for a state is 0, including selects.
- Fetch and decode:
  - S18: MAR<-PC (GatePC, LD_MAR); PC<-PC+1 (PCMUX 0, LD_PC); ->33.
  - S33: CS, LD_MDR; stays while !READY, else ->35.
  - S35: IR<-MDR (GateMDR, LD_IR); ->32.
  - S32: LD_BEN; dispatch on IR[15:12]: 0->S0, 1->S1, 2->S2, 3->S3, 4->S4, 5->S5, 6->S6, 7->S7, 9->S9, 10->S10, 11->S11, 12->S12, 14->S14, 15->S15. Opcodes 8 (RTI) and 13 (reserved) act as NOPs and go ->18.
- Branch and jumps:
  - S0: ->22 if BEN, else ->18.
  - S22: PC<-PC+off9 (ADDR1 0, ADDR2 2, PCMUX 2, LD_PC); ->18.
  - S12 (JMP): PC<-BaseR (SR1MUX 1, ADDR1 1, ADDR2 0, PCMUX 2, LD_PC); ->18.
  - S4 (JSR/JSRR): R7<-PC (GatePC, DRMUX 1, LD_REG); ->21 if IR[11], else ->20.
  - S21: PC<-PC+off11 (ADDR2 3). S20: as S12. Both ->18.
- Operates and LEA:
  - S1 ADD, S5 AND, S9 NOT: DR<-ALU (SR1MUX 1, DRMUX 0, ALUK 00/01/10, GateALU, LD_REG, LD_CC); ->18.
  - S14 LEA: DR<-PC+off9 (MARMUX 1, GateMARMUX, LD_REG, LD_CC); ->18.
- Address states load MAR through GateMARMUX with MARMUX 1 and LD_MAR:
  - S2 LD, S3 ST, S10 LDI, S11 STI: PC+off9.
  - S6 LDR, S7 STR: BaseR+off6 (SR1MUX 1, ADDR1 1, ADDR2 1).
  - Next: S2, S6 ->25; S3, S7 ->23; S10 ->24; S11 ->29.
- Memory read states S24, S25, S29: same outputs and READY wait as S33. Next: S25->27, S24->26, S29->31.
- S26, S31: MAR<-MDR (GateMDR, LD_MAR). Next: S26->25, S31->23.
- S27: DR<-MDR (GateMDR, DRMUX 0, LD_REG, LD_CC); ->18.
- S23: MDR<-SR (SR1MUX 0, ALUK 11, GateALU, LD_MDR, CS 0); ->16.
- S16: CS, WE; stays while !READY, else ->18.
- TRAP:
  - S15: MAR<-ZEXT(trapvect8) (MARMUX 0, GateMARMUX, LD_MAR); ->28.
  - S28: MDR<-M (CS, LD_MDR) and R7<-PC (GatePC, DRMUX 1, LD_REG) in the same cycle; waits on READY; ->30.
  - S30: PC<-MDR (GateMDR, PCMUX 1, LD_PC); ->18.
- An undefined state goes ->18 with all outputs 0.

## Timing
- RESET high at an edge sets state=S18, N=0, Z=1, P=0, BEN=0.
- While RESET is high, all control outputs are forced to 0. Fetch begins on the first cycle after RESET falls.
- RESET wins over any pending wait or transition, including mid-memory access.
- Each state lasts exactly one cycle, except wait states (33, 24, 25, 29, 28, 16), which last until READY=1 is sampled.
- CC and BEN update at the same edge as their load strobe and are visible the following cycle. S0 therefore uses the BEN loaded in S32.
- Minimum instruction latency: 5 cycles for ADD (18, 33, 35, 32, 1) with READY always 1; 6 cycles for a taken BR.

## Test plan
- Reset: RESET=1 for 2 cycles -> all controls 0, Z=1, BEN=0. Release -> S18 asserts GatePC, LD_MAR, LD_PC with PCMUX 0.
- Fetch wait: READY=0 for 3 cycles in S33 -> LD_MDR and CS held 4 cycles total, then LD_IR pulses once.
- CC: pulse LD_CC with BUS=0x8000, 0x0000, 0x0001 -> NZP=100, 010, 001 respectively. BUS changes without LD_CC -> no change.
- BR: IR=0x0A05 (BRnp) with Z=1 -> BEN=0, returns to S18 without LD_PC. With P=1 -> S22 asserts LD_PC with PCMUX 2, ADDR2 2.
- STI IR=0xB002 -> state sequence 11, 29, 31, 23, 16. S16 asserts CS=1 and WE=1 until READY.
- TRAP IR=0xF025 -> S15 MARMUX 0 and GateMARMUX. S28 asserts GatePC, DRMUX 1, LD_REG, CS, LD_MDR. S30 asserts PCMUX 1, LD_PC.
